// File: rtl/rs_wakeup_table.sv
// Reservation-station wakeup table: tracks operand readiness and drives selector requests.
// Optional squash port enabled by defining RS_SQUASH_EN.
module rs_wakeup_table #(
  parameter int WIDTH    = 16,
  parameter int TAG_BITS = 6,
  localparam int IDX_BITS = $clog2(WIDTH)
) (
`ifdef RS_SQUASH_EN
  input  logic                squash,
`endif
  input  logic                clock,
  input  logic                reset,
  input  logic                dispatch_en,
  input  logic [TAG_BITS-1:0] dispatch_dest_tag,
  input  logic [TAG_BITS-1:0] dispatch_src1_tag,
  input  logic                dispatch_src1_rdy,
  input  logic [TAG_BITS-1:0] dispatch_src2_tag,
  input  logic                dispatch_src2_rdy,
  input  logic                cdb_en,
  input  logic [TAG_BITS-1:0] cdb_tag,
  input  logic [WIDTH-1:0]    gnt,
  output logic [WIDTH-1:0]    req,
  output logic                issue_valid,
  output logic [TAG_BITS-1:0] issue_dest_tag,
  output logic [IDX_BITS-1:0] issue_idx,
  output logic [IDX_BITS:0]   free_count,
  output logic                full
);

  logic [WIDTH-1:0]    valid_q, valid_d;
  logic [WIDTH-1:0]    src1_rdy_q, src1_rdy_d;
  logic [WIDTH-1:0]    src2_rdy_q, src2_rdy_d;
  logic [TAG_BITS-1:0] dest_q [WIDTH];
  logic [TAG_BITS-1:0] dest_d [WIDTH];
  logic [TAG_BITS-1:0] src1_q [WIDTH];
  logic [TAG_BITS-1:0] src1_d [WIDTH];
  logic [TAG_BITS-1:0] src2_q [WIDTH];
  logic [TAG_BITS-1:0] src2_d [WIDTH];

  logic                issue_valid_q, issue_valid_d;
  logic [TAG_BITS-1:0] issue_dest_tag_q, issue_dest_tag_d;
  logic [IDX_BITS-1:0] issue_idx_q, issue_idx_d;

  logic [WIDTH-1:0]    eff_gnt;
  logic [IDX_BITS-1:0] slot_idx;
  logic                slot_found;
  logic                dispatch_ok;
  logic                kill;
  logic [IDX_BITS:0]   free_cnt;

`ifdef RS_SQUASH_EN
  assign kill = squash;
`else
  assign kill = 1'b0;
`endif

  assign req         = valid_q & src1_rdy_q & src2_rdy_q;
  assign eff_gnt     = gnt & req;
  assign free_count  = free_cnt;
  assign full        = (free_cnt == '0);
  assign dispatch_ok = dispatch_en & slot_found;

  assign issue_valid    = issue_valid_q;
  assign issue_dest_tag = issue_dest_tag_q;
  assign issue_idx      = issue_idx_q;

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      free_cnt = free_cnt + (IDX_BITS+1)'(!valid_q[i]);
    end
  end

  // Scan high to low so the lowest free index wins.
  always_comb begin
    slot_found = 1'b0;
    slot_idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        slot_found = 1'b1;
        slot_idx   = IDX_BITS'(i);
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    src1_rdy_d = src1_rdy_q;
    src2_rdy_d = src2_rdy_q;
    dest_d     = dest_q;
    src1_d     = src1_q;
    src2_d     = src2_q;

    issue_valid_d    = |eff_gnt;
    issue_dest_tag_d = issue_dest_tag_q;
    issue_idx_d      = issue_idx_q;

    for (int i = 0; i < WIDTH; i++) begin
      if (valid_q[i] && cdb_en && src1_q[i] == cdb_tag)
        src1_rdy_d[i] = 1'b1;
      if (valid_q[i] && cdb_en && src2_q[i] == cdb_tag)
        src2_rdy_d[i] = 1'b1;
      if (eff_gnt[i]) begin
        valid_d[i]       = 1'b0;
        issue_dest_tag_d = dest_q[i];
        issue_idx_d      = IDX_BITS'(i);
      end
    end

    // Chosen slot is invalid pre-edge, so it never collides with a grant.
    if (dispatch_ok) begin
      valid_d[slot_idx]    = 1'b1;
      dest_d[slot_idx]     = dispatch_dest_tag;
      src1_d[slot_idx]     = dispatch_src1_tag;
      src2_d[slot_idx]     = dispatch_src2_tag;
      src1_rdy_d[slot_idx] = dispatch_src1_rdy |
                             (cdb_en && cdb_tag == dispatch_src1_tag);
      src2_rdy_d[slot_idx] = dispatch_src2_rdy |
                             (cdb_en && cdb_tag == dispatch_src2_tag);
    end

    if (kill) begin
      valid_d          = '0;
      issue_valid_d    = 1'b0;
      issue_dest_tag_d = issue_dest_tag_q;
      issue_idx_d      = issue_idx_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q          <= '0;
      issue_valid_q    <= 1'b0;
      issue_dest_tag_q <= '0;
      issue_idx_q      <= '0;
    end else begin
      valid_q          <= valid_d;
      issue_valid_q    <= issue_valid_d;
      issue_dest_tag_q <= issue_dest_tag_d;
      issue_idx_q      <= issue_idx_d;
    end
  end

  // Payload is qualified by valid_q and needs no reset.
  always_ff @(posedge clock) begin
    src1_rdy_q <= src1_rdy_d;
    src2_rdy_q <= src2_rdy_d;
    dest_q     <= dest_d;
    src1_q     <= src1_d;
    src2_q     <= src2_d;
  end

endmodule

// File: tb/tb_rs_wakeup_table.sv
// Directed testbench for rs_wakeup_table.
// Define RS_SQUASH_EN to also exercise the squash path.
module tb_rs_wakeup_table;

  logic        clock = 1'b0;
  logic        reset;
  logic        dispatch_en;
  logic [5:0]  dispatch_dest_tag;
  logic [5:0]  dispatch_src1_tag;
  logic        dispatch_src1_rdy;
  logic [5:0]  dispatch_src2_tag;
  logic        dispatch_src2_rdy;
  logic        cdb_en;
  logic [5:0]  cdb_tag;
  logic [15:0] gnt;
  logic [15:0] req;
  logic        issue_valid;
  logic [5:0]  issue_dest_tag;
  logic [3:0]  issue_idx;
  logic [4:0]  free_count;
  logic        full;
`ifdef RS_SQUASH_EN
  logic        squash;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rs_wakeup_table #(.WIDTH(16), .TAG_BITS(6)) dut (
`ifdef RS_SQUASH_EN
    .squash(squash),
`endif
    .clock(clock),
    .reset(reset),
    .dispatch_en(dispatch_en),
    .dispatch_dest_tag(dispatch_dest_tag),
    .dispatch_src1_tag(dispatch_src1_tag),
    .dispatch_src1_rdy(dispatch_src1_rdy),
    .dispatch_src2_tag(dispatch_src2_tag),
    .dispatch_src2_rdy(dispatch_src2_rdy),
    .cdb_en(cdb_en),
    .cdb_tag(cdb_tag),
    .gnt(gnt),
    .req(req),
    .issue_valid(issue_valid),
    .issue_dest_tag(issue_dest_tag),
    .issue_idx(issue_idx),
    .free_count(free_count),
    .full(full)
  );

  always @(posedge clock)
    assert ($onehot0(gnt)) else $error("illegal multi-hot gnt %h", gnt);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dispatch_en = 0;
    cdb_en      = 0;
    gnt         = '0;
  endtask

  task automatic disp(input logic [5:0] d, input logic [5:0] s1,
                      input logic r1, input logic [5:0] s2,
                      input logic r2);
    dispatch_en       = 1;
    dispatch_dest_tag = d;
    dispatch_src1_tag = s1;
    dispatch_src1_rdy = r1;
    dispatch_src2_tag = s2;
    dispatch_src2_rdy = r2;
  endtask

  initial begin
    reset = 1;
    idle();
    disp(0, 0, 0, 0, 0);
    dispatch_en = 0;
    cdb_tag = 0;
`ifdef RS_SQUASH_EN
    squash = 0;
`endif
    step(); step();
    reset = 0;
    step();
    check("rst_req", req, 0);
    check("rst_free", free_count, 16);
    check("rst_full", full, 0);
    check("rst_iv", issue_valid, 0);
    check("rst_idest", issue_dest_tag, 0);
    check("rst_iidx", issue_idx, 0);

    // basic dispatch then issue
    disp(5, 3, 1, 4, 1);
    step(); idle();
    check("d1_req", req, 16'h0001);
    check("d1_free", free_count, 15);
    gnt = 16'h0001;
    step(); idle();
    check("g1_iv", issue_valid, 1);
    check("g1_dest", issue_dest_tag, 5);
    check("g1_idx", issue_idx, 0);
    check("g1_req", req, 0);
    check("g1_free", free_count, 16);
    step();
    check("g1_iv_drop", issue_valid, 0);
    check("g1_dest_hold", issue_dest_tag, 5);

    // CDB wakeup
    disp(10, 7, 0, 8, 1);
    step(); idle();
    check("w_req0", req, 0);
    cdb_en = 1; cdb_tag = 7;
    // bypass dispatch in the same cycle as the wakeup
    disp(11, 9, 0, 8, 1);
    cdb_tag = 9;
    step(); idle();
    check("w_bypass_req", req, 16'h0002);
    cdb_en = 1; cdb_tag = 7;
    step(); idle();
    check("w_wake_req", req, 16'h0003);
    gnt = 16'h0002;
    step(); idle();
    check("w_dest", issue_dest_tag, 11);
    check("w_idx", issue_idx, 1);
    gnt = 16'h0001;
    step(); idle();
    check("w_dest0", issue_dest_tag, 10);
    check("w_free", free_count, 16);

    // one tag wakes both sources
    disp(12, 20, 0, 20, 0);
    step(); idle();
    check("both_req0", req, 0);
    cdb_en = 1; cdb_tag = 20;
    step(); idle();
    check("both_req1", req, 16'h0001);
    gnt = 16'h0001;
    step(); idle();
    check("both_free", free_count, 16);

    // fill, entry 2 left not ready
    for (int i = 0; i < 16; i++) begin
      disp(6'(i), (i == 2) ? 6'd30 : 6'd1, i != 2, 6'd2, 1);
      step();
    end
    idle();
    check("fill_full", full, 1);
    check("fill_free", free_count, 0);
    check("fill_req", req, 16'hFFFB);
    disp(40, 1, 1, 2, 1);
    gnt = 16'h8000;
    step(); idle();
    check("ovf_iv", issue_valid, 1);
    check("ovf_dest", issue_dest_tag, 15);
    check("ovf_idx", issue_idx, 15);
    check("ovf_free", free_count, 1);
    check("ovf_req", req, 16'h7FFB);
    check("ovf_full", full, 0);
    disp(50, 1, 1, 2, 1);
    step(); idle();
    check("refill_free", free_count, 0);
    check("refill_req", req, 16'hFFFB);
    check("refill_iv", issue_valid, 0);
    check("refill_dhold", issue_dest_tag, 15);
    gnt = 16'h8000;
    step(); idle();
    check("refill_dest", issue_dest_tag, 50);
    gnt = 16'h0004;
    step(); idle();
    check("nogo_iv", issue_valid, 0);
    check("nogo_free", free_count, 1);
    check("nogo_req", req, 16'h7FFB);
    check("nogo_dest", issue_dest_tag, 50);
    check("nogo_idx", issue_idx, 15);

    // reset mid-operation
    gnt = 16'h0001;
    reset = 1;
    step(); idle();
    reset = 0;
    check("mrst_free", free_count, 16);
    check("mrst_req", req, 0);
    check("mrst_iv", issue_valid, 0);
    check("mrst_dest", issue_dest_tag, 0);

`ifdef RS_SQUASH_EN
    for (int i = 0; i < 4; i++) begin
      disp(6'(i + 1), 1, 1, 2, 1);
      step();
    end
    idle();
    check("sq_pre_free", free_count, 12);
    disp(60, 1, 1, 2, 1);
    gnt = 16'h0001;
    squash = 1;
    step(); idle();
    squash = 0;
    check("sq_free", free_count, 16);
    check("sq_req", req, 0);
    check("sq_iv", issue_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
